// File: rtl/clock_time_keeper.sv
// BCD HH:MM:SS time-of-day keeper fed by a tick strobe, with a validated valid/ready time set.
// Define CLOCK_ALARM_EN to add the alarm comparator and its ports.
module clock_time_keeper #(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned SUB_W         = 10
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_enable,
    input  logic             i_tick,
    input  logic             i_set_valid,
    input  logic [23:0]      i_set_time,
`ifdef CLOCK_ALARM_EN
    input  logic [23:0]      i_alarm_time,
    input  logic             i_alarm_arm,
    output logic             o_alarm,
`endif
    output logic             o_set_ready,
    output logic             o_set_err,
    output logic [23:0]      o_time,
    output logic [SUB_W-1:0] o_sub,
    output logic             o_sec_pulse
);

    typedef enum logic {StIdle, StApply} state_e;

    state_e           r_state;
    logic [23:0]      r_cap;
    logic             r_set_ready;
    logic             r_set_err;
    logic [23:0]      r_time;
    logic [SUB_W-1:0] r_sub;
    logic             r_sec_pulse;

    logic             w_sub_wrap;
    logic             w_count;
    logic             w_sec_inc;
    logic             w_load;
    logic [23:0]      w_time_next;

    function automatic logic bcd_valid(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        return (h1 <= 4'd2) && (h0 <= 4'd9) && !((h1 == 4'd2) && (h0 > 4'd3)) &&
               (m1 <= 4'd5) && (m0 <= 4'd9) && (s1 <= 4'd5) && (s0 <= 4'd9);
    endfunction

    // Full seconds carry chain; hour rolls 23 -> 00.
    function automatic logic [23:0] bcd_next(input logic [23:0] t);
        logic [3:0] h1, h0, m1, m0, s1, s0;
        {h1, h0, m1, m0, s1, s0} = t;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1 = 4'd0;
                        if ((h1 == 4'd2) && (h0 == 4'd3)) begin
                            h1 = 4'd0;
                            h0 = 4'd0;
                        end else if (h0 == 4'd9) begin
                            h0 = 4'd0;
                            h1 = h1 + 4'd1;
                        end else begin
                            h0 = h0 + 4'd1;
                        end
                    end
                end
            end
        end
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    // A set request in IDLE wins over a tick in the same cycle.
    assign w_count     = (r_state == StIdle) && !i_set_valid && i_tick && i_enable;
    assign w_sub_wrap  = (r_sub == SUB_W'(TICKS_PER_SEC - 1));
    assign w_sec_inc   = w_count && w_sub_wrap;
    assign w_load      = (r_state == StApply) && !r_set_err;
    assign w_time_next = bcd_next(r_time);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= StIdle;
            r_cap       <= '0;
            r_set_ready <= 1'b1;
            r_set_err   <= 1'b0;
            r_time      <= '0;
            r_sub       <= '0;
            r_sec_pulse <= 1'b0;
        end else begin
            r_sec_pulse <= 1'b0;
            r_set_err   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_set_valid) begin
                        r_cap       <= i_set_time;
                        r_set_err   <= !bcd_valid(i_set_time);
                        r_set_ready <= 1'b0;
                        r_state     <= StApply;
                    end else if (w_count) begin
                        if (w_sub_wrap) begin
                            r_sub       <= '0;
                            r_time      <= w_time_next;
                            r_sec_pulse <= 1'b1;
                        end else begin
                            r_sub <= r_sub + SUB_W'(1);
                        end
                    end
                end
                StApply: begin
                    if (w_load) begin
                        r_time <= r_cap;
                        r_sub  <= '0;
                    end
                    r_set_ready <= 1'b1;
                    r_state     <= StIdle;
                end
                default: begin
                    r_set_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

    assign o_set_ready = r_set_ready;
    assign o_set_err   = r_set_err;
    assign o_time      = r_time;
    assign o_sub       = r_sub;
    assign o_sec_pulse = r_sec_pulse;

`ifdef CLOCK_ALARM_EN
    logic r_time_chg;
    logic r_alarm;

    // Only a fresh change of o_time may trigger; equality present at arming does not.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_time_chg <= 1'b0;
            r_alarm    <= 1'b0;
        end else begin
            r_time_chg <= w_sec_inc || w_load;
            if (!i_alarm_arm) begin
                r_alarm <= 1'b0;
            end else if (r_time_chg && (r_time == i_alarm_time)) begin
                r_alarm <= 1'b1;
            end
        end
    end

    assign o_alarm = r_alarm;
`endif

endmodule
